// File: rtl/bomber_pkg.sv
// Shared tile-map types, geometry and palette for the map renderer.
package bomber_pkg;

  typedef enum logic [1:0] {
    TILE_EMPTY = 2'd0,
    TILE_WALL  = 2'd1,
    TILE_BRICK = 2'd2,
    TILE_BOMB  = 2'd3
  } tile_t;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } ctrl_state_t;

  localparam int MAP_COLS  = 20;
  localparam int MAP_ROWS  = 15;
  localparam int TILE_SIZE = 40;
  localparam int MAP_CELLS = MAP_COLS * MAP_ROWS;
  localparam int ADDR_W    = 9;

  localparam logic [23:0] COLOUR_EMPTY = 24'h228B22;
  localparam logic [23:0] COLOUR_WALL  = 24'h808080;
  localparam logic [23:0] COLOUR_BRICK = 24'hA0522D;
  localparam logic [23:0] COLOUR_BOMB  = 24'h202020;

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [3:0] row, input logic [4:0] col);
    return ADDR_W'(row) * ADDR_W'(MAP_COLS) + ADDR_W'(col);
  endfunction

endpackage

// File: rtl/map_ram.sv
// 300-cell tile map: one synchronous read port, one write port, read-old-data on collision.
module map_ram
  import bomber_pkg::*;
(
  input  logic              clock_50,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  tile_t             wdata,
  input  logic [ADDR_W-1:0] raddr,
  output tile_t             rdata
);

  tile_t mem [MAP_CELLS];

  always_ff @(posedge clock_50) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/map_render.sv
// Tile-map renderer: raster position counters, 2-cycle pixel pipeline, map init/update control.
// Define MAP_SYNC_UPDATE_EN to buffer map writes in a FIFO that drains only during vertical blank.
module map_render
  import bomber_pkg::*;
(
  input  logic       clock_50,
  input  logic       reset,
  input  logic       HS_in,
  input  logic       VS_in,
  input  logic       blank_in,
  input  logic       SOF,
  input  logic       EOF,
  input  logic       SOL,
  input  logic       EOL,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [4:0] wr_col,
  input  logic [3:0] wr_row,
  input  logic [1:0] wr_tile,
  output logic       HS,
  output logic       VS,
  output logic       blank,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue
);

  localparam logic [5:0] SUB_LAST = 6'(TILE_SIZE - 1);
  localparam logic [5:0] BOMB_LO  = 6'd10;
  localparam logic [5:0] BOMB_HI  = 6'd29;

  function automatic logic [23:0] tile_colour(input tile_t t, input logic [5:0] sx, input logic [5:0] sy);
    logic inner;
    inner = (sx >= BOMB_LO) && (sx <= BOMB_HI) && (sy >= BOMB_LO) && (sy <= BOMB_HI);
    case (t)
      TILE_WALL:  return COLOUR_WALL;
      TILE_BRICK: return COLOUR_BRICK;
      TILE_BOMB:  return inner ? COLOUR_BOMB : COLOUR_EMPTY;
      default:    return COLOUR_EMPTY;
    endcase
  endfunction

  logic [5:0]        sub_x, sub_y, cur_sub_x, cur_sub_y;
  logic [4:0]        tile_x, cur_tile_x;
  logic [3:0]        tile_y, cur_tile_y;
  logic [ADDR_W-1:0] rd_addr_raw, rd_addr;
  tile_t             rd_tile;

  // Position of the pixel currently on the inputs; the registers hold the previous active pixel.
  always_comb begin
    cur_sub_x  = '0;
    cur_tile_x = '0;
    if (!SOL) begin
      if (sub_x == SUB_LAST) begin
        cur_tile_x = tile_x + 5'd1;
      end else begin
        cur_sub_x  = sub_x + 6'd1;
        cur_tile_x = tile_x;
      end
    end
    cur_sub_y  = SOF ? 6'd0 : sub_y;
    cur_tile_y = SOF ? 4'd0 : tile_y;
  end

  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      sub_x  <= '0;
      tile_x <= '0;
      sub_y  <= '0;
      tile_y <= '0;
    end else if (blank_in) begin
      sub_x  <= cur_sub_x;
      tile_x <= cur_tile_x;
      if (EOL && !EOF) begin
        if (cur_sub_y == SUB_LAST) begin
          sub_y  <= '0;
          tile_y <= cur_tile_y + 4'd1;
        end else begin
          sub_y  <= cur_sub_y + 6'd1;
          tile_y <= cur_tile_y;
        end
      end else begin
        sub_y  <= cur_sub_y;
        tile_y <= cur_tile_y;
      end
    end
  end

  assign rd_addr_raw = cell_addr(cur_tile_y, cur_tile_x);
  assign rd_addr     = (rd_addr_raw < ADDR_W'(MAP_CELLS)) ? rd_addr_raw : '0;

  // Stage 1: map read issued, raster controls and sub-tile offsets travel alongside.
  logic       hs_p1, vs_p1, vld_p1;
  logic [5:0] sub_x_p1, sub_y_p1;

  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      hs_p1    <= 1'b0;
      vs_p1    <= 1'b0;
      vld_p1   <= 1'b0;
      sub_x_p1 <= '0;
      sub_y_p1 <= '0;
    end else begin
      hs_p1    <= HS_in;
      vs_p1    <= VS_in;
      vld_p1   <= blank_in;
      sub_x_p1 <= cur_sub_x;
      sub_y_p1 <= cur_sub_y;
    end
  end

  // Stage 2: colour formed from tile code and offsets, blanked outside the active area.
  logic [23:0] rgb_p2;
  assign rgb_p2 = vld_p1 ? tile_colour(rd_tile, sub_x_p1, sub_y_p1) : 24'h0;

  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      HS    <= 1'b0;
      VS    <= 1'b0;
      blank <= 1'b0;
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else begin
      HS    <= hs_p1;
      VS    <= vs_p1;
      blank <= vld_p1;
      {red, green, blue} <= rgb_p2;
    end
  end

  ctrl_state_t       state;
  logic [ADDR_W-1:0] init_addr;
  logic              run;

  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      state     <= ST_INIT;
      init_addr <= '0;
      run       <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          if (init_addr == ADDR_W'(MAP_CELLS - 1)) begin
            state <= ST_RUN;
            run   <= 1'b1;
          end else begin
            init_addr <= init_addr + 1'b1;
          end
        end
        default: run <= 1'b1;
      endcase
    end
  end

  logic              wr_legal;
  logic [ADDR_W-1:0] wr_addr;
  logic              upd_pend;
  logic [ADDR_W-1:0] upd_addr;
  tile_t             upd_tile;

  assign wr_legal = (wr_col < 5'(MAP_COLS)) && (wr_row < 4'(MAP_ROWS));
  assign wr_addr  = cell_addr(wr_row, wr_col);

`ifdef MAP_SYNC_UPDATE_EN
  localparam logic [2:0] FIFO_DEPTH = 3'd4;

  logic [ADDR_W+1:0] fifo_mem [4];
  logic [1:0]        wr_ptr, rd_ptr;
  logic [2:0]        fifo_cnt;
  logic              vblank, push, pop;

  assign wr_ready = run && (fifo_cnt != FIFO_DEPTH);
  assign push     = wr_valid && wr_ready && wr_legal;
  assign pop      = vblank && (fifo_cnt != 3'd0);
  assign upd_pend = pop;
  assign upd_addr = fifo_mem[rd_ptr][ADDR_W+1:2];
  assign upd_tile = tile_t'(fifo_mem[rd_ptr][1:0]);

  always_ff @(posedge clock_50) begin
    if (push) fifo_mem[wr_ptr] <= {wr_addr, wr_tile};
  end

  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      vblank   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      // Updates only land between EOF and the next SOF so a frame never shows a torn map.
      if (blank_in && SOF)      vblank <= 1'b0;
      else if (blank_in && EOF) vblank <= 1'b1;
    end
  end
`else
  assign wr_ready = run;

  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      upd_pend <= 1'b0;
      upd_addr <= '0;
      upd_tile <= TILE_EMPTY;
    end else begin
      upd_pend <= wr_valid && wr_ready && wr_legal;
      upd_addr <= wr_addr;
      upd_tile <= tile_t'(wr_tile);
    end
  end
`endif

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  tile_t             ram_wdata;

  assign ram_we    = (state == ST_INIT) || upd_pend;
  assign ram_waddr = (state == ST_INIT) ? init_addr : upd_addr;
  assign ram_wdata = (state == ST_INIT) ? TILE_EMPTY : upd_tile;

  map_ram u_map_ram (
    .clock_50 (clock_50),
    .we       (ram_we),
    .waddr    (ram_waddr),
    .wdata    (ram_wdata),
    .raddr    (rd_addr),
    .rdata    (rd_tile)
  );

endmodule
